// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out serializer.
// State encoding and counter sizing helper.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR
  } piso_state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for one serial frame.
// Saturates at WIDTH-1 and flags the last data bit.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_V = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == LAST_V);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with valid/ready input and gapless frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_last,
  output logic             busy
);

  piso_state_t      r_state;
  piso_state_t      w_next;
  logic [WIDTH-1:0] r_shreg;
  logic             w_accept;
  logic             w_last;
  logic             w_final;
  logic             w_bit;
  logic             w_shift;
  logic             w_clear;

  assign w_shift = (r_state == SHIFT);
  assign w_bit   = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];

`ifdef PISO_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^din;
    end
  end

  assign w_final = (r_state == PAR);
  assign sout    = w_shift ? w_bit :
                   (r_state == PAR) ? r_par : 1'b0;
`else
  assign w_final = w_shift & w_last;
  assign sout    = w_shift ? w_bit : 1'b0;
`endif

  assign din_ready  = (r_state == IDLE) | w_final;
  assign w_accept   = din_valid & din_ready;
  assign busy       = (r_state != IDLE);
  assign sout_valid = busy;
  assign frame_last = w_final;

  // Counter restarts on every accept and whenever the shift phase ends.
  assign w_clear = w_accept | ~w_shift | w_last;

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clear (w_clear),
    .i_enable(w_shift),
    .o_last  (w_last)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = SHIFT;
      end
      SHIFT: begin
        if (w_last) begin
`ifdef PISO_PARITY_EN
          w_next = PAR;
`else
          w_next = w_accept ? SHIFT : IDLE;
`endif
        end
      end
      PAR: begin
        w_next = w_accept ? SHIFT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
    end else if (w_accept) begin
      r_shreg <= din;
    end else if (w_shift) begin
      if (MSB_FIRST != 0) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first and MSB-first instances
// checked every cycle against a queue-of-frame-bits model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic a_rdy, a_so, a_sv, a_fl, a_bz;
  logic b_rdy, b_so, b_sv, b_fl, b_bz;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(a_rdy), .sout(a_so), .sout_valid(a_sv),
    .frame_last(a_fl), .busy(a_bz)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(b_rdy), .sout(b_so), .sout_valid(b_sv),
    .frame_last(b_fl), .busy(b_bz)
  );

  always #5 clk = ~clk;

  // Downstream right-shift register fed by the LSB-first instance.
  logic [W-1:0] sr;
  always @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else if (a_sv) sr <= {a_so, sr[W-1:1]};
  end

  typedef struct packed {
    logic bl;
    logic bm;
    logic last;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    logic h;
    ent_t e;
    h = (q.size() > 0);
    e = h ? q[0] : '0;
    chk("a_sout", a_so, e.bl);
    chk("b_sout", b_so, e.bm);
    chk("a_sout_valid", a_sv, h);
    chk("b_sout_valid", b_sv, h);
    chk("a_frame_last", a_fl, h & e.last);
    chk("b_frame_last", b_fl, h & e.last);
    chk("a_din_ready", a_rdy, q.size() <= 1);
    chk("b_din_ready", b_rdy, q.size() <= 1);
    chk("a_busy", a_bz, h);
    chk("b_busy", b_bz, h);
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      e.bl = d[i];
      e.bm = d[W-1-i];
      e.last = (i == FL - 1);
      q.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.bl = ^d;
    e.bm = ^d;
    e.last = 1'b1;
    q.push_back(e);
`endif
  endtask

  // One clock: model accepts when idle or on the final frame bit.
  task automatic tick(output bit acc);
    acc = din_valid && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) push_frame(din);
    @(negedge clk);
    chk_all();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit a;
    int k;
    din = d;
    din_valid = 1'b1;
    a = 1'b0;
    k = 0;
    while (!a && k < 20) begin
      tick(a);
      k++;
    end
    if (!a) chk("send_timeout", 1'b0, 1'b1);
    din_valid = 1'b0;
  endtask

  initial begin
    bit a;
    @(negedge clk);
    chk_all();
    rst = 1'b1;
    idle(2);

    send(4'b0001);
    idle(FL);
`ifndef PISO_PARITY_EN
    total++;
    assert (sr === 4'b0001) else begin
      bad++;
      $error("FAIL chain_q observed=%b expected=%b", sr, 4'b0001);
    end
`endif
    idle(2);

    send(4'hA);
    send(4'h5);
    idle(FL + 2);

    send(4'h3);
    for (int i = 0; i < W - 1; i++) begin
      din = W'($urandom);
      din_valid = ~din_valid;
      tick(a);
    end
    din_valid = 1'b0;
    idle(FL + 2);

    send(4'hF);
    tick(a);
    rst = 1'b0;
    q.delete();
    #1;
    chk_all();
    @(posedge clk);
    @(negedge clk);
    chk_all();
    rst = 1'b1;
    idle(FL + 2);

    send(4'b0111);
    idle(FL + 1);

    for (int i = 0; i < 300; i++) begin
      din = W'($urandom);
      din_valid = ($urandom_range(0, 2) != 0);
      tick(a);
    end
    din_valid = 1'b0;
    idle(FL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
